r2r_adc_core: RTL and testbench
===============================

Name:
r2r_adc_core

Overview:
- Tracking/ramp ADC built around an external R2R-ladder DAC and an external analog comparator.
- Generates a continuous up/down triangle ramp on the R2R ladder at WAVE_FREQ.
- On every transition of the comparator output, latches the ramp code present at that moment into ADC_OUT.
- Sits between the board R2R header/comparator pin and downstream display/logging logic.

Parameters:
- WIDTH, 8, R2R ladder resolution in bits (ramp code range 0..2^WIDTH-1).
- CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
- WAVE_FREQ, 1000, triangle wave frequency in Hz (one full up+down period).
- VREF_MV, 3300, full-scale ladder voltage in mV. Used only by the optional feature.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  active-high ramp/conversion enable.
- comparator  input  1  asynchronous comparator output; 1 = analog input above ladder voltage.
- R2R_out  output  WIDTH  current ramp code driving the R2R ladder.
- ADC_OUT  output  16  last captured conversion result.

Behaviour:
- Reset (reset=0, asynchronous):
  - R2R_out=0, ADC_OUT=0, ramp direction=up, divider=0.
  - Synchronizer and edge registers=0.
- Step divider:
  - DIV = CLOCK_FREQ / (WAVE_FREQ * 2 * (2^WIDTH-1)), integer-truncated, forced to a minimum of 1.
  - Defaults give DIV=196.
  - Divider counts 0..DIV-1; a step tick is issued on the cycle it equals DIV-1, and it then wraps to 0.
- Ramp:
  - On each tick, R2R_out increments while direction=up and decrements while direction=down.
  - On the tick that reaches 2^WIDTH-1, direction becomes down; on the tick that reaches 0, direction becomes up.
  - Endpoints are never held for more than one step.
  - Sequence: 0,1,…,255,254,…,1,0,1,…; period = 510*DIV clocks (99,960 clocks at defaults).
- enable=0 (synchronous):
  - Divider=0, R2R_out=0, direction=up.
  - ADC_OUT holds its last value and no captures occur.
  - On re-enable the ramp restarts from 0; the first increment occurs DIV clocks after enable is sampled high.
- Comparator path:
  - Two-flop synchronizer (s1, s2), then a previous-value register p.
  - Edge = s2 != p.
  - When Edge=1 and enable=1, ADC_OUT <= zero-extended R2R_out (current value) on that clock edge.
  - Latency: comparator change sampled at edge k, so ADC_OUT updates at edge k+2.
- Both rising and falling comparator edges capture.
- No capture while the comparator is static; ADC_OUT holds.
- A capture and a ramp tick on the same cycle: the pre-tick R2R_out value is captured.
- WIDTH up to 16 is supported. Upper bits of ADC_OUT are 0.

Optional Feature:
- Macro: R2R_ADC_MV_SCALE_EN.
- Defined:
  - The captured code is converted to millivolts: ADC_OUT = (code * VREF_MV) / (2^WIDTH-1), truncated.
  - This is computed in a one-cycle registered stage, so capture latency becomes k+3.
  - At defaults, code 255 gives 3300 and code 128 gives 1656.
- Undefined: ADC_OUT is the raw zero-extended code as above.

Test Plan:
- Reset value: hold reset=0 for 3 clocks with enable=0 and comparator=0 -> R2R_out=0 and ADC_OUT=0. Assert reset=0 mid-ramp -> both outputs return to 0 immediately, without waiting for a clock.
- Ramp timing: release reset, set enable=1 -> R2R_out=1 after 196 clocks, 255 after 255*196 clocks, 254 one DIV later, and 0 again at 99,960 clocks.
- Capture latency: enable with comparator 0→1 at ramp code 0 -> ADC_OUT=0. Hold comparator for 500 µs, then toggle it -> ADC_OUT equals the R2R_out value at the capture edge, exactly 2 clocks after the sample edge. ADC_OUT is unchanged while the comparator is static.
- Both edges: toggle the comparator on a rising-ramp segment and on a falling-ramp segment -> each toggle produces a capture.
- Enable drop: deassert enable mid-ramp -> R2R_out=0 on the next clock and ADC_OUT holds. Comparator toggles while disabled -> no ADC_OUT change.
- With R2R_ADC_MV_SCALE_EN: capture at code 255 -> ADC_OUT=3300; capture at code 0 -> ADC_OUT=0; latency is 3 clocks.

Source files
------------

// File: rtl/r2r_adc_core_if.sv
// ---------------------------------------------------------------------------
// r2r_adc_core_if
// Purpose : groups the board-facing signals of the R2R ramp ADC core.
// Signals :
//   enable      - active-high ramp/conversion enable (driven by the master)
//   comparator  - raw, asynchronous comparator output (driven by the master)
//   R2R_out     - current ramp code on the R2R ladder (driven by the core)
//   ADC_OUT     - last captured conversion result (driven by the core)
// Modports: master = board/system side, slave = r2r_adc_core.
// ---------------------------------------------------------------------------
interface r2r_adc_core_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             comparator;
    logic [WIDTH-1:0] R2R_out;
    logic [15:0]      ADC_OUT;

    modport master (
        output enable,
        output comparator,
        input  R2R_out,
        input  ADC_OUT
    );

    modport slave (
        input  enable,
        input  comparator,
        output R2R_out,
        output ADC_OUT
    );
endinterface

// File: rtl/r2r_adc_core.sv
// ---------------------------------------------------------------------------
// r2r_adc_core
// Purpose : tracking/ramp ADC. Drives a continuous up/down triangle ramp onto
//           an external R2R ladder and, on every comparator transition,
//           latches the ramp code present at that moment into ADC_OUT.
// Ports   :
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - r2r_adc_core_if.slave (enable, comparator, R2R_out, ADC_OUT)
// Parameters: WIDTH (ladder bits, <=16), CLOCK_FREQ (Hz), WAVE_FREQ (Hz, one
//           full up+down period), VREF_MV (ladder full scale in mV).
// Optional: define R2R_ADC_MV_SCALE_EN to report ADC_OUT in millivolts
//           (code * VREF_MV / (2^WIDTH-1)); this adds one register stage.
// ---------------------------------------------------------------------------
module r2r_adc_core #(
    parameter int WIDTH      = 8,
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int WAVE_FREQ  = 1000,
    parameter int VREF_MV    = 3300
) (
    input  logic           clk,
    input  logic           reset,
    r2r_adc_core_if.slave  bus
);

    localparam int     MAX_CODE = (1 << WIDTH) - 1;
    // Clocks per ramp step so that 2*(2^WIDTH-1) steps span one wave period.
    localparam longint DIV_RAW  = longint'(CLOCK_FREQ) /
                                  (longint'(WAVE_FREQ) * 2 * longint'(MAX_CODE));
    localparam int     DIV      = (DIV_RAW < 1) ? 1 : int'(DIV_RAW);
    localparam int     DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [WIDTH-1:0] TOP_M1   = WIDTH'(MAX_CODE - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Millivolt conversion, truncating. 48 bits covers 16-bit codes times
    // any realistic reference voltage without overflow.
    function automatic logic [15:0] to_mv(input logic [WIDTH-1:0] code);
        logic [47:0] prod;
        prod  = 48'(code) * 48'(VREF_MV);
        to_mv = 16'(prod / 48'(MAX_CODE));
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] code_q;
    logic             dir_down;
    logic             step_tick;

    logic             cmp_s1;
    logic             cmp_s2;
    logic             cmp_prev;
    logic             capture;
    logic [15:0]      adc_q;

    assign step_tick   = bus.enable && (div_cnt == DIV_LAST);
    assign bus.R2R_out = code_q;
    assign bus.ADC_OUT = adc_q;

    // ---- ramp generator: step divider and triangle code ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            code_q   <= '0;
            dir_down <= 1'b0;
        end else if (!bus.enable) begin
            div_cnt  <= '0;
            code_q   <= '0;
            dir_down <= 1'b0;
        end else begin
            div_cnt <= step_tick ? '0 : div_cnt + 1'b1;
            if (step_tick) begin
                // Direction flips on the step that lands on an endpoint, so
                // neither endpoint is held for more than one step.
                if (!dir_down) begin
                    code_q <= code_q + ONE;
                    if (code_q == TOP_M1) dir_down <= 1'b1;
                end else begin
                    code_q <= code_q - ONE;
                    if (code_q == ONE) dir_down <= 1'b0;
                end
            end
        end
    end

    // ---- comparator synchronizer and transition detect ----
    // Any transition (either polarity) of the synchronized comparator
    // requests a capture of the code currently on the ladder.
    assign capture = (cmp_s2 != cmp_prev) && bus.enable;

`ifdef R2R_ADC_MV_SCALE_EN
    logic             vld_p0;
    logic [WIDTH-1:0] code_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_s1   <= 1'b0;
            cmp_s2   <= 1'b0;
            cmp_prev <= 1'b0;
            vld_p0   <= 1'b0;
            adc_q    <= '0;
        end else begin
            cmp_s1   <= bus.comparator;
            cmp_s2   <= cmp_s1;
            cmp_prev <= cmp_s2;
            vld_p0   <= capture;
            // ---- p0 -> output: millivolt scaling ----
            if (vld_p0) adc_q <= to_mv(code_p0);
        end
    end

    // ---- capture -> p0: raw code held for the scaling stage ----
    always_ff @(posedge clk) begin
        if (capture) code_p0 <= code_q;
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_s1   <= 1'b0;
            cmp_s2   <= 1'b0;
            cmp_prev <= 1'b0;
            adc_q    <= '0;
        end else begin
            cmp_s1   <= bus.comparator;
            cmp_s2   <= cmp_s1;
            cmp_prev <= cmp_s2;
            // ---- capture -> output: raw code, zero-extended ----
            if (capture) adc_q <= 16'(code_q);
        end
    end
`endif

endmodule

// File: tb/tb_r2r_adc_core.sv
// ---------------------------------------------------------------------------
// tb_r2r_adc_core
// Randomized scoreboard bench for r2r_adc_core. The reference model derives
// the ladder code from the number of enabled clocks (triangle of period
// 2*(2^WIDTH-1) steps) and expects each comparator transition to show up on
// ADC_OUT a fixed number of clocks later. A reduced CLOCK_FREQ keeps a full
// ramp period short. Honours R2R_ADC_MV_SCALE_EN for the millivolt build.
// ---------------------------------------------------------------------------
module tb_r2r_adc_core;

    localparam int WIDTH      = 8;
    localparam int CLOCK_FREQ = 10_000_000;
    localparam int WAVE_FREQ  = 1000;
    localparam int VREF_MV    = 3300;
    localparam int MAXC       = (1 << WIDTH) - 1;
    localparam int DIV_CALC   = CLOCK_FREQ / (WAVE_FREQ * 2 * MAXC);
    localparam int DIV        = (DIV_CALC < 1) ? 1 : DIV_CALC;
    localparam int PERIOD     = 2 * MAXC * DIV;
`ifdef R2R_ADC_MV_SCALE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    r2r_adc_core_if #(.WIDTH(WIDTH)) bus ();

    r2r_adc_core #(
        .WIDTH      (WIDTH),
        .CLOCK_FREQ (CLOCK_FREQ),
        .WAVE_FREQ  (WAVE_FREQ),
        .VREF_MV    (VREF_MV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc = 0;
    int   n = 0;
    int   hold_val = 0;
    int   checks = 0;
    int   errors = 0;

    // Ladder code after k enabled clocks.
    function automatic int tri_code(input int k);
        int s;
        s = (k / DIV) % (2 * MAXC);
        return (s <= MAXC) ? s : 2 * MAXC - s;
    endfunction

    function automatic int expect_out(input int code);
`ifdef R2R_ADC_MV_SCALE_EN
        return (code * VREF_MV) / MAXC;
`else
        return code;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model time base: edges seen, and enabled edges since the last restart.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset || !bus.enable) n <= 0;
        else                       n <= n + 1;
    end

    // Monitor: ramp every cycle, capture when due, otherwise ADC_OUT must hold.
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_r2r", int'(bus.R2R_out), 0);
            chk("reset_adc", int'(bus.ADC_OUT), 0);
            hold_val = 0;
            sbq.delete();
        end else begin
            chk("r2r_out", int'(bus.R2R_out), tri_code(n));
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                hold_val = e.val;
                chk("capture", int'(bus.ADC_OUT), hold_val);
            end else begin
                chk("adc_hold", int'(bus.ADC_OUT), hold_val);
            end
        end
    end

    // Called just after a falling edge: the next rising edge samples the new
    // comparator level; the code two enabled edges later is what gets latched.
    task automatic toggle_cmp();
        bus.comparator = ~bus.comparator;
        if (bus.enable)
            sbq.push_back('{due: cyc + LAT + 1, val: expect_out(tri_code(n + 2))});
    endtask

    task automatic run_random(input int cycles, input int gap_max);
        int since;
        since = 100;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            since++;
            if (since >= 6 && (cycles - i) > 6 && $urandom_range(gap_max, 0) == 0) begin
                toggle_cmp();
                since = 0;
            end
        end
    endtask

    // Toggle when the captured code will sit at ramp phase s_target
    // (0..2*MAXC-1, so direction is explicit); optionally on a tick cycle.
    task automatic wait_phase(input int s_target, input bit tick_align);
        int s;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 8 && !hit; i++) begin
            @(negedge clk);
            s = ((n + 2) / DIV) % (2 * MAXC);
            if (s == s_target && (!tick_align || ((n + 3) % DIV) == 0)) begin
                toggle_cmp();
                hit = 1'b1;
            end
        end
        chk("wait_phase_reached", int'(hit), 1);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #(900_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable     = 1'b0;
        bus.comparator = 1'b0;
        reset          = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_r2r", int'(bus.R2R_out), 0);
        chk("init_adc", int'(bus.ADC_OUT), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Enable with a 0->1 comparator edge at code 0, then first ramp step.
        bus.enable = 1'b1;
        toggle_cmp();
        repeat (DIV - 1) @(negedge clk);
        chk("ramp_before_step", int'(bus.R2R_out), 0);
        @(negedge clk);
        chk("ramp_first_step", int'(bus.R2R_out), 1);
        repeat (8) @(negedge clk);

        // Rising segment, peak, tick-coincident capture, falling segment.
        wait_phase(100, 1'b0);
        wait_phase(MAXC, 1'b0);
        wait_phase(300, 1'b1);
        wait_phase(400, 1'b0);
        wait_phase(0, 1'b0);

        // Random enable/disable segments with random comparator activity.
        for (int seg = 0; seg < 8; seg++) begin
            bus.enable = ($urandom_range(3, 0) != 0);
            run_random($urandom_range(3000, 200), 80);
        end

        // Asynchronous reset mid-ramp, outputs must clear before any edge.
        bus.enable = 1'b1;
        run_random(1500, 40);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_r2r", int'(bus.R2R_out), 0);
        chk("async_reset_adc", int'(bus.ADC_OUT), 0);
        @(negedge clk);
        bus.comparator = 1'b0;
        bus.enable     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        bus.enable = 1'b1;
        repeat (8) @(negedge clk);
        wait_phase(MAXC, 1'b0);
        wait_phase(MAXC + 20, 1'b1);
        run_random(1000, 60);
        bus.enable = 1'b0;
        run_random(300, 20);

        repeat (10) @(negedge clk);
        chk("queue_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
